mmr_scrub_register: RTL
=======================

Name: mmr_scrub_register

Overview:
- Parametrised K-way modular-redundant register with a bitwise majority voter, per-replica mismatch detection, and automatic scrubbing of corrupted replicas.
- Saturating error counter and SEU injection port.
- Successor to the fixed 3/5-way TMR register primitives: generalises to any odd K_MMR from 3 to 7 and adds self-repair and fault telemetry.
- Used for configuration and status registers inside the mmr_registers layer.

Parameters:
- WIDTH, 16, data width in bits (1..64).
- K_MMR, 3, replica count; odd, 3..7. Anything else is an elaboration-time $fatal.
- RESET_VALUE, '0, value loaded into every replica on reset.
- SCRUB_EN, 1, 1 = disagreeing replicas are rewritten with the voted value; 0 = detect only.
- CNT_WIDTH, 16, error counter width (2..32).

Ports:
- clk  in  1  single clock for all replicas.
- rst  in  1  synchronous, active-high reset.
- wr_en_i  in  1  write strobe.
- data_i  in  WIDTH  write data.
- inject_en_i  in  1  SEU injection strobe (verification/debug).
- inject_idx_i  in  $clog2(K_MMR)  target replica.
- inject_mask_i  in  WIDTH  bits to flip in the target replica.
- err_clear_i  in  1  clears err_count_o.
- data_o  out  WIDTH  bitwise majority of the replicas.
- mismatch_o  out  1  registered: at least one replica disagreed with the vote in the previous cycle.
- multi_fault_o  out  1  registered: two or more replicas disagreed in the previous cycle.
- replica_err_o  out  K_MMR  registered per-replica disagreement vector.
- err_count_o  out  CNT_WIDTH  saturating count of mismatch cycles.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all replicas <= RESET_VALUE.
  - mismatch_o, multi_fault_o, replica_err_o, err_count_o <= 0.
  - reset overrides every other input, including injection.
- Vote: data_o[b] = 1 iff more than K_MMR/2 replicas hold 1 at bit b. It is combinational from the replica registers.
- Mismatch vector: m[k] = (replica[k] != data_o), combinational.
- Next replica value, in priority order:
  1. wr_en_i=1: every replica <= data_i.
  2. else if SCRUB_EN=1 and m[k]=1: replica[k] <= data_o.
  3. else: hold.
- Injection: if inject_en_i=1 and inject_idx_i < K_MMR, that replica's next value (from the rules above) is XORed with inject_mask_i. An out-of-range index is ignored; it is not an error.
- Latency:
  - data_i is visible on data_o one cycle after the wr_en_i edge.
  - An injected fault is masked on data_o the same cycle it lands.
  - The fault is flagged on mismatch_o one cycle later.
  - With SCRUB_EN=1 the fault is repaired on the edge that raises mismatch_o, so an isolated SEU gives exactly a one-cycle mismatch_o pulse.
- Status registers:
  - replica_err_o <= m.
  - mismatch_o <= |m.
  - multi_fault_o <= popcount(m) >= 2.
  - For K_MMR=3, multi_fault_o means data_o may already be wrong.
- Error counter:
  - err_count_o increments by 1 on every edge where |m=1, and saturates at 2^CNT_WIDTH-1.
  - err_clear_i=1 loads 0 and takes priority over a simultaneous increment.
- Write during mismatch: the write repairs all replicas. The mismatch is still recorded (status and counter) for that edge.
- Inject during write: the write data lands, the target replica gets write data ^ mask, and a mismatch is flagged on the following edge.
- SCRUB_EN=0: faults persist. mismatch_o stays high and the counter increments every cycle until the next write or reset.

Test Plan:
- K_MMR=3, WIDTH=16: reset, then write 0xA5A5 -> data_o=0xA5A5 next cycle; mismatch_o=0, err_count_o=0.
- Inject idx=1, mask=0x0001 (no write) -> data_o stays 0xA5A5; mismatch_o=1 and replica_err_o=3'b010 for exactly 1 cycle; err_count_o=1; replica 1 scrubbed.
- K_MMR=5: inject idx=0 mask 0x00FF, then idx=3 mask 0x00FF on consecutive cycles with SCRUB_EN=0 -> data_o unchanged; multi_fault_o=1 from the second detection; err_count_o increments every cycle until a write of 0x1234 clears all faults.
- CNT_WIDTH=2, SCRUB_EN=0, persistent fault held 6 cycles -> err_count_o saturates at 3. Then err_clear_i together with a mismatch -> err_count_o=0.
- Edge cases:
  - write 0xFFFF with simultaneous inject idx=2 mask 0x8000 -> data_o=0xFFFF; replica_err_o=3'b100 on the next cycle.
  - inject_idx_i=3 with K_MMR=3 -> no effect.
  - rst asserted mid-fault -> all outputs zero and data_o=RESET_VALUE next cycle.

Source files
------------

// File: rtl/mmr_scrub_register.sv
// K-way redundant register: bitwise majority vote, per-replica mismatch flags, optional scrub of bad replicas.
// Vote is combinational from the replicas; status and counter lag by one cycle; no backpressure, accepts every cycle.
module mmr_scrub_register #(
    parameter int              WIDTH       = 16,
    parameter int              K_MMR       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit              SCRUB_EN    = 1'b1,
    parameter int              CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     inject_en_i,
    input  logic [$clog2(K_MMR)-1:0] inject_idx_i,
    input  logic [WIDTH-1:0]         inject_mask_i,
    input  logic                     err_clear_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     mismatch_o,
    output logic                     multi_fault_o,
    output logic [K_MMR-1:0]         replica_err_o,
    output logic [CNT_WIDTH-1:0]     err_count_o
);

    localparam int IDX_W = $clog2(K_MMR);

    if (K_MMR < 3 || K_MMR > 7 || (K_MMR % 2) == 0) begin : g_bad_k
        $fatal(1, "mmr_scrub_register: K_MMR must be odd and within 3..7");
    end
    if (WIDTH < 1 || WIDTH > 64 || CNT_WIDTH < 2 || CNT_WIDTH > 32) begin : g_bad_w
        $fatal(1, "mmr_scrub_register: WIDTH or CNT_WIDTH out of range");
    end

    logic [WIDTH-1:0] rep     [K_MMR];
    logic [WIDTH-1:0] rep_nxt [K_MMR];
    logic [WIDTH-1:0] voted;
    logic [K_MMR-1:0] m;
    logic             multi_nxt;

    always_comb begin
        int ones;
        voted = '0;
        ones  = 0;
        for (int b = 0; b < WIDTH; b++) begin
            ones = 0;
            for (int k = 0; k < K_MMR; k++) begin
                ones = ones + (rep[k][b] ? 1 : 0);
            end
            voted[b] = (ones > K_MMR / 2);
        end
    end

    always_comb begin
        int n;
        n = 0;
        m = '0;
        for (int k = 0; k < K_MMR; k++) begin
            m[k] = (rep[k] != voted);
            n    = n + (m[k] ? 1 : 0);
        end
        multi_nxt = (n >= 2);
    end

    // Injection flips the already-resolved next value, so it also corrupts a fresh write.
    always_comb begin
        for (int k = 0; k < K_MMR; k++) begin
            rep_nxt[k] = rep[k];
            if (wr_en_i) begin
                rep_nxt[k] = data_i;
            end else if (SCRUB_EN && m[k]) begin
                rep_nxt[k] = voted;
            end
            if (inject_en_i && inject_idx_i == IDX_W'(k)) begin
                rep_nxt[k] = rep_nxt[k] ^ inject_mask_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < K_MMR; k++) begin
                rep[k] <= RESET_VALUE;
            end
            mismatch_o    <= 1'b0;
            multi_fault_o <= 1'b0;
            replica_err_o <= '0;
            err_count_o   <= '0;
        end else begin
            for (int k = 0; k < K_MMR; k++) begin
                rep[k] <= rep_nxt[k];
            end
            mismatch_o    <= |m;
            multi_fault_o <= multi_nxt;
            replica_err_o <= m;
            if (err_clear_i) begin
                err_count_o <= '0;
            end else if (|m && err_count_o != {CNT_WIDTH{1'b1}}) begin
                err_count_o <= err_count_o + 1'b1;
            end
        end
    end

    assign data_o = voted;

endmodule
